// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and the next-PC selector encoding for the fetch PC unit.
package fetch_pc_unit_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
  localparam logic [31:0] IMEM_LAST  = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  // Source of the next fetch address, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_EXC,
    SEL_ERET,
    SEL_HOLD,
    SEL_BR,
    SEL_SEQ
  } npc_sel_t;

endpackage

// File: rtl/fetch_pc_unit_npc_select.sv
// Combinational next-PC priority encoder and mux for the fetch stage.
module npc_select
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = PC_RESET,
  parameter logic [31:0] HANDLER_PC = PC_HANDLER
) (
  input  logic        reset,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] epc,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  output npc_sel_t    sel,
  output logic [31:0] next_pc
);

  // Pick the highest-priority source: reset, exception, ERET, stall, redirect, sequential.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel = SEL_SEQ;
    if (reset)         sel = SEL_RESET;
    else if (exc_req)  sel = SEL_EXC;
    else if (eret_req) sel = SEL_ERET;
    else if (stall)    sel = SEL_HOLD;
    else if (br_taken) sel = SEL_BR;
  end

  // Route the selected source onto next_pc; epc is used exactly as CP0 supplies it.
  always_comb begin
    next_pc = pc_plus4;
    unique case (sel)
      SEL_RESET: next_pc = RESET_PC;
      SEL_EXC:   next_pc = HANDLER_PC;
      SEL_ERET:  next_pc = epc;
      SEL_HOLD:  next_pc = pc;
      SEL_BR:    next_pc = br_target;
      SEL_SEQ:   next_pc = pc_plus4;
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with exception vectoring, ERET return, AdEL
// detection and handler-residency tracking for the CP0 block.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = PC_RESET,
  parameter logic [31:0] HANDLER_PC = PC_HANDLER,
  parameter logic [31:0] IMEM_BASE  = PC_RESET,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        if_adel,
  output logic [4:0]  if_exccode,
  output logic        in_handler,
  output logic [7:0]  handler_entries
);

  // Handler residency states.
  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_HANDLER = 1'b1;

  // Highest word address the ROM can return.
  localparam logic [31:0] IMEM_HI = IMEM_BASE + 32'(4 * (IMEM_WORDS - 1));

  npc_sel_t    sel;
  logic [31:0] next_pc;
  logic        state_q;

  assign pc_plus4 = pc + 32'd4;

  npc_select #(
    .RESET_PC   (RESET_PC),
    .HANDLER_PC (HANDLER_PC)
  ) u_npc_select (
    .reset     (reset),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .epc       (epc),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .sel       (sel),
    .next_pc   (next_pc)
  );

  // PC register: reset is already the top priority inside the selector.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    pc <= next_pc;
  end

  // Fetch slot is valid from the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (reset) if_valid <= 1'b0;
    else       if_valid <= 1'b1;
  end

  // Handler residency: exception enters (and re-enters), ERET leaves; exc wins over eret.
  always_ff @(posedge clk) begin
    if (reset)                 state_q <= ST_RUN;
    else if (sel == SEL_EXC)   state_q <= ST_HANDLER;
    else if (sel == SEL_ERET)  state_q <= ST_RUN;
  end

  // Saturating count of handler entries.
  always_ff @(posedge clk) begin
    if (reset)
      handler_entries <= 8'd0;
    else if (sel == SEL_EXC && handler_entries != 8'hFF)
      handler_entries <= handler_entries + 8'd1;
  end

  assign in_handler = (state_q == ST_HANDLER);

  // Misaligned or outside the ROM window; wrap to zero lands below the base.
  assign if_adel    = (pc[1:0] != 2'b00) || (pc < IMEM_BASE) || (pc > IMEM_HI);
  assign if_exccode = if_adel ? EXC_ADEL : 5'd0;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage program counter unit for the pipelined MIPS core with interrupt/exception support. It holds the architectural fetch PC and computes next-PC with a fixed priority: reset, exception vector, ERET return, stall hold, branch/jump redirect, sequential +4. It presents the PC directly to the word-addressed instruction ROM (base 0x00003000, handler image at 0x00004180). It flags fetch address errors (AdEL) and tracks handler residency for the CP0 block.

## Interface
Parameters:
- RESET_PC, 32'h00003000: first fetch address after reset.
- HANDLER_PC, 32'h00004180: exception/interrupt entry vector.
- IMEM_BASE, 32'h00003000: lowest legal fetch address.
- IMEM_WORDS, 4096: ROM depth; highest legal fetch address is IMEM_BASE + 4*(IMEM_WORDS-1) = 0x00006FFC.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from decode; holds the PC.
- br_taken  in  1  branch/jump redirect valid; single-cycle qualifier for br_target.
- br_target  in  32  redirect address.
- exc_req  in  1  exception/interrupt accepted by CP0 this cycle.
- eret_req  in  1  ERET committed this cycle.
- epc  in  32  return address from CP0.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, which is the link value source.
- if_valid  out  1  fetch slot holds a real instruction.
- if_adel  out  1  fetch address error on current pc.
- if_exccode  out  5  5'd4 when if_adel, else 5'd0.
- in_handler  out  1  core is executing the exception handler.
- handler_entries  out  8  saturating count of handler entries.

## Operation
- The PC register loads next_pc on every rising edge. The priority is:
  1. reset → RESET_PC.
  2. exc_req → HANDLER_PC.
  3. eret_req → epc, used unmodified.
  4. stall → pc, held.
  5. br_taken → br_target.
  6. Otherwise → pc + 4.
- exc_req overrides stall, br_taken and eret_req in the same cycle.
- eret_req overrides stall.
- Arithmetic is 32-bit modulo. 0xFFFFFFFC + 4 wraps to 0x00000000, and that address is flagged AdEL; no other action is taken.
- if_adel is combinational from the pc register. It is 1 when any of these hold:
  - pc[1:0] != 0
  - pc < IMEM_BASE
  - pc > IMEM_BASE + 4*(IMEM_WORDS-1)
- When if_adel=1, if_valid is still 1. Downstream stages turn the slot into an exception.
- State machine, encoded in in_handler:
  - RUN (0) → HANDLER (1) on exc_req.
  - HANDLER → RUN on eret_req.
  - exc_req while in HANDLER: the PC re-vectors to HANDLER_PC, the state stays HANDLER, and the counter still increments.
  - eret_req while in RUN: the PC loads epc and the state stays RUN.
  - exc_req and eret_req together: exc_req wins and the state is HANDLER.
- handler_entries increments on each exc_req and saturates at 8'hFF.
- if_valid is 0 while reset is asserted. It is 1 from the first edge after reset deasserts, and it is not deasserted by stall or redirects. Flushing is the pipeline registers' job.

## Timing
- All outputs are derived from registers or from combinational logic on registers. No input reaches an output combinationally.
- Request-to-pc latency is 1 cycle. An input sampled at edge N is visible on pc after edge N.
- Reset values:
  - pc = RESET_PC
  - pc_plus4 = RESET_PC + 4
  - if_valid = 0
  - if_adel = 0
  - if_exccode = 0
  - in_handler = 0
  - handler_entries = 0
- Reset asserted mid-operation overrides everything at the next edge: pending exc_req/eret_req are discarded and the counter clears.
- A stall held for K cycles keeps pc constant for K edges. Sequential fetch resumes on the first edge with stall=0.
- br_taken is honoured only on edges where stall=0 and no exc_req/eret_req is asserted. If it is masked, it is lost; the requester must re-assert it.

## Structure
- The shared package holds:
  - PC_RESET = 32'h00003000
  - PC_HANDLER = 32'h00004180
  - IMEM_LAST = 32'h00006FFC
  - EXC_ADEL = 5'd4
  - the npc_sel_t enum {SEL_RESET, SEL_EXC, SEL_ERET, SEL_HOLD, SEL_BR, SEL_SEQ}
- One sub-module, npc_select, is natural. It is the combinational priority encoder plus mux producing npc_sel_t and next_pc.
- The top level holds the PC register, the in_handler state, the counter, if_valid and the AdEL check.

## Test plan
- Reset and sequential fetch: hold reset 2 cycles, then release for 3 cycles. pc goes 0x3000 → 0x3004 → 0x3008 → 0x300C, and if_valid rises on the first edge after release.
- Stall and branch: in one cycle assert stall=1, br_taken=1 and br_target=0x3100, and pc holds. In the next cycle assert stall=0, br_taken=1 and br_target=0x3100; pc becomes 0x3100, then 0x3104.
- Exception priority: at pc=0x3020, assert exc_req, br_taken and stall together. pc becomes 0x4180, in_handler=1 and handler_entries=1. Next assert eret_req with epc=0x3020; pc becomes 0x3020 and in_handler=0.
- Nested and simultaneous requests: from inside the handler, assert exc_req. pc becomes 0x4180, in_handler stays 1 and handler_entries=2. Then assert exc_req and eret_req together; exc_req wins and pc becomes 0x4180.
- AdEL cases: eret to epc=0x3002 gives if_adel=1 and if_exccode=4. Branch to 0x7000 gives if_adel=1. Branch to 0x6FFC gives if_adel=0.
- Reset mid-handler, with saturation run separately:
  - With in_handler=1 and handler_entries=5, assert reset. All outputs take their reset values after one edge.
  - Issue 300 exc_req pulses. handler_entries reads 255.
